xm_memory_responder: RTL and testbench

//  Memory-side end of the core's memory request interface: accepts single-cycle

---
 rtl/xm_memory_responder.sv | 147 ++++++++++++++
 tb/tb_xm_memory_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xm_memory_responder.sv
// -----------------------------------------------------------------------------
// xm_memory_responder
//
// Memory-side end of the core's memory request interface. A single-cycle
// request (memEn_i with memRW_i/byteOp_i/adr_i/data_i) is latched in IDLE.
// The responder then holds memBusy_o high for WAIT_CYCLES+1 cycles and
// performs the access on the completion edge. Storage is a byte array that is
// byte-addressed and little-endian. The same port serves instruction fetch and
// data access.
//
// Parameters
//   WORD         data/address bus width (byte lanes assume a 16-bit word)
//   ADDR_W       byte-address bits decoded; storage is 2**ADDR_W bytes
//   WAIT_CYCLES  extra busy cycles before an access completes (0 allowed)
//
// Ports
//   clk_i      clock; all state updates on posedge
//   arst_i     asynchronous active-high reset
//   memEn_i    request strobe, only honoured in IDLE
//   memRW_i    0 = read, 1 = write
//   byteOp_i   1 = byte access, 0 = word access
//   adr_i      byte address (only the low ADDR_W bits are decoded)
//   data_i     write data (byte writes use data_i[7:0])
//   memBusy_o  access in progress
//   memWr_o    one-cycle pulse: data_o holds fresh read data
//   data_o     read data, held until the next read completes
//   err_o      one-cycle pulse: a misaligned word access completed
// -----------------------------------------------------------------------------
module xm_memory_responder #(
    parameter int WORD        = 16,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] adr_i,
    input  logic [WORD-1:0] data_i,
    output logic            memBusy_o,
    output logic            memWr_o,
    output logic [WORD-1:0] data_o,
    output logic            err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    // Counter must hold WAIT_CYCLES; keep at least one bit when it is zero.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Latched request. Pure datapath, so these registers carry no reset.
    logic              rw_q;
    logic              byte_q;
    logic [ADDR_W-1:0] adr_q;
    logic [15:0]       wdata_q;

    logic [7:0]        mem [DEPTH];

    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] adr_lo;
    logic [ADDR_W-1:0] adr_hi;

    // Address bits above ADDR_W are ignored, so accesses alias (wrap).
    logic              unused_adr_upper;
    assign unused_adr_upper = ^adr_i[WORD-1:ADDR_W];

    assign done       = (state == BUSY) && (cnt == '0);
    assign misaligned = !byte_q && adr_q[0];
    assign adr_lo     = adr_q;
    // For an aligned word the upper byte sits at a+1, which is just a|1.
    assign adr_hi     = {adr_q[ADDR_W-1:1], 1'b1};

    always_ff @(posedge clk_i) begin
        if (state == IDLE && memEn_i) begin
            rw_q    <= memRW_i;
            byte_q  <= byteOp_i;
            adr_q   <= adr_i[ADDR_W-1:0];
            wdata_q <= data_i[15:0];
        end
    end

    // Storage write. Gating on the registered state means that a reset
    // during the wait returns the FSM to IDLE and drops the pending write.
    always_ff @(posedge clk_i) begin
        if (done && rw_q && !misaligned) begin
            mem[adr_lo] <= wdata_q[7:0];
            if (!byte_q) begin
                mem[adr_hi] <= wdata_q[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            memBusy_o <= 1'b0;
            memWr_o   <= 1'b0;
            err_o     <= 1'b0;
            data_o    <= '0;
        end else begin
            memWr_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (memEn_i) begin
                        cnt       <= CNT_LOAD;
                        memBusy_o <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Completion edge. Any memEn_i seen here is dropped.
                        memBusy_o <= 1'b0;
                        state     <= IDLE;
                        err_o     <= misaligned;
                        if (!rw_q) begin
                            memWr_o <= 1'b1;
                            if (misaligned) begin
                                data_o <= '0;
                            end else if (byte_q) begin
                                data_o <= WORD'(mem[adr_lo]);
                            end else begin
                                data_o <= WORD'({mem[adr_hi], mem[adr_lo]});
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xm_memory_responder.sv
module tb_xm_memory_responder;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        en2 = 1'b0;
    logic        en0 = 1'b0;
    logic        rw = 1'b0;
    logic        bop = 1'b0;
    logic [15:0] adr = '0;
    logic [15:0] wdata = '0;

    logic        busy2, wr2, err2;
    logic [15:0] data2;
    logic        busy0, wr0, err0;
    logic [15:0] data0;

    bit          sel_dut = 1'b0;
    logic        obs_busy, obs_wr, obs_err;
    logic [15:0] obs_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    xm_memory_responder #(.WORD(16), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .arst_i(arst), .memEn_i(en2), .memRW_i(rw), .byteOp_i(bop),
        .adr_i(adr), .data_i(wdata), .memBusy_o(busy2), .memWr_o(wr2),
        .data_o(data2), .err_o(err2)
    );

    xm_memory_responder #(.WORD(16), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .arst_i(arst), .memEn_i(en0), .memRW_i(rw), .byteOp_i(bop),
        .adr_i(adr), .data_i(wdata), .memBusy_o(busy0), .memWr_o(wr0),
        .data_o(data0), .err_o(err0)
    );

    assign obs_busy = sel_dut ? busy0 : busy2;
    assign obs_wr   = sel_dut ? wr0   : wr2;
    assign obs_err  = sel_dut ? err0  : err2;
    assign obs_data = sel_dut ? data0 : data2;

    // Issues one request and collects what the DUT does with it; no checks.
    task automatic access(input bit sel, input logic r_w, input logic b, input logic [15:0] a,
                          input logic [15:0] d, output int busy_n, output logic wr,
                          output logic er, output logic [15:0] rd, output logic after);
        bit fin;
        @(negedge clk);
        sel_dut = sel;
        rw = r_w; bop = b; adr = a; wdata = d;
        if (sel) en0 = 1'b1; else en2 = 1'b1;
        @(posedge clk);
        #1;
        en0 = 1'b0; en2 = 1'b0;
        busy_n = 0; wr = 1'b0; er = 1'b0; rd = '0; fin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs_busy) begin
                busy_n++;
            end else begin
                wr = obs_wr; er = obs_err; rd = obs_data; fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout adr=%h busy still high after 20 cycles", a);
        end
        @(negedge clk);
        after = obs_wr | obs_err;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy2); end
        n_checks++; if (wr2 !== 1'b0)   begin n_fail++; $display("FAIL reset_wr got=%b exp=0", wr2); end
        n_checks++; if (err2 !== 1'b0)  begin n_fail++; $display("FAIL reset_err got=%b exp=0", err2); end
        n_checks++; if (data2 !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", data2); end
        n_checks++; if (busy0 !== 1'b0 || data0 !== 16'h0) begin
            n_fail++; $display("FAIL reset_dut0 busy=%b data=%h exp 0/0000", busy0, data0);
        end
        arst = 1'b0;
    endtask

    task automatic test_word_rw();
        int b; logic w, e, aft; logic [15:0] r, x;
        access(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, b, w, e, r, aft);
        n_checks++; if (b !== 3) begin n_fail++; $display("FAIL wr_busy got=%0d exp=3", b); end
        n_checks++; if (w !== 1'b0 || e !== 1'b0) begin n_fail++; $display("FAIL wr_pulses memWr=%b err=%b exp 0/0", w, e); end
        exp_q.push_back(16'hBEEF);
        access(0, 1'b0, 1'b0, 16'h0010, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (b !== 3) begin n_fail++; $display("FAIL rd_busy got=%0d exp=3", b); end
        n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL rd_memwr got=%b exp=1", w); end
        n_checks++; if (r !== x) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", r, x); end
        n_checks++; if (aft !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_width memWr still high got=%b exp=0", aft); end
    endtask

    task automatic test_byte_ops();
        int b; logic w, e, aft; logic [15:0] r, x;
        access(0, 1'b1, 1'b1, 16'h0011, 16'hC35A, b, w, e, r, aft);
        n_checks++; if (b !== 3 || w !== 1'b0) begin n_fail++; $display("FAIL bwr busy=%0d memWr=%b exp 3/0", b, w); end
        exp_q.push_back(16'h5AEF);
        access(0, 1'b0, 1'b0, 16'h0010, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x || w !== 1'b1) begin n_fail++; $display("FAIL word_after_bwr got=%h memWr=%b exp=%h", r, w, x); end
        exp_q.push_back(16'h00EF);
        access(0, 1'b0, 1'b1, 16'h0010, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x) begin n_fail++; $display("FAIL byte_rd_lo got=%h exp=%h", r, x); end
        exp_q.push_back(16'h005A);
        access(0, 1'b0, 1'b1, 16'h0011, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x || e !== 1'b0) begin n_fail++; $display("FAIL byte_rd_odd got=%h err=%b exp=%h/0", r, e, x); end
    endtask

    task automatic test_misaligned();
        int b; logic w, e, aft; logic [15:0] r, x;
        access(0, 1'b1, 1'b0, 16'h0012, 16'h7788, b, w, e, r, aft);
        access(0, 1'b1, 1'b0, 16'h0014, 16'h6655, b, w, e, r, aft);
        access(0, 1'b1, 1'b0, 16'h0013, 16'h1234, b, w, e, r, aft);
        n_checks++; if (b !== 3) begin n_fail++; $display("FAIL mis_wr_busy got=%0d exp=3", b); end
        n_checks++; if (e !== 1'b1 || w !== 1'b0) begin n_fail++; $display("FAIL mis_wr_pulses err=%b memWr=%b exp 1/0", e, w); end
        n_checks++; if (aft !== 1'b0) begin n_fail++; $display("FAIL mis_wr_err_width got=%b exp=0", aft); end
        exp_q.push_back(16'h7788);
        access(0, 1'b0, 1'b0, 16'h0012, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x) begin n_fail++; $display("FAIL mis_wr_kept_12 got=%h exp=%h", r, x); end
        exp_q.push_back(16'h6655);
        access(0, 1'b0, 1'b0, 16'h0014, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x) begin n_fail++; $display("FAIL mis_wr_kept_14 got=%h exp=%h", r, x); end
        exp_q.push_back(16'h0000);
        access(0, 1'b0, 1'b0, 16'h0013, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x || w !== 1'b1 || e !== 1'b1) begin
            n_fail++; $display("FAIL mis_rd data=%h memWr=%b err=%b exp %h/1/1", r, w, e, x);
        end
        n_checks++; if (b !== 3) begin n_fail++; $display("FAIL mis_rd_busy got=%0d exp=3", b); end
    endtask

    task automatic test_held_request();
        logic [9:0] busy_pat, wr_pat;
        logic [15:0] x;
        busy_pat = '0; wr_pat = '0;
        @(negedge clk);
        sel_dut = 1'b0;
        rw = 1'b0; bop = 1'b0; adr = 16'h0010;
        en2 = 1'b1;
        exp_q.push_back(16'h5AEF);
        exp_q.push_back(16'h5AEF);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) en2 = 1'b0;
            @(negedge clk);
            busy_pat[c] = obs_busy;
            wr_pat[c]   = obs_wr;
            if (obs_wr) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL held_extra_read data=%h exp none", obs_data);
                end else begin
                    x = exp_q.pop_front();
                    n_checks++; if (obs_data !== x) begin n_fail++; $display("FAIL held_data got=%h exp=%h", obs_data, x); end
                end
            end
        end
        n_checks++; if (busy_pat !== 10'b0001110111) begin n_fail++; $display("FAIL held_busy_pattern got=%b exp=0001110111", busy_pat); end
        n_checks++; if (wr_pat !== 10'b0010001000) begin n_fail++; $display("FAIL held_memwr_pattern got=%b exp=0010001000", wr_pat); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL held_missing_reads left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        int b; logic w, e, aft; logic [15:0] r, x;
        access(0, 1'b1, 1'b0, 16'h0020, 16'hAAAA, b, w, e, r, aft);
        @(negedge clk);
        sel_dut = 1'b0;
        rw = 1'b1; bop = 1'b0; adr = 16'h0020; wdata = 16'h1234;
        en2 = 1'b1;
        @(posedge clk);
        #1;
        en2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", busy2); end
        arst = 1'b1;
        #1;
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", busy2); end
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy2 !== 1'b0 || data2 !== 16'h0) begin n_fail++; $display("FAIL rst_after busy=%b data=%h exp 0/0000", busy2, data2); end
        exp_q.push_back(16'hAAAA);
        access(0, 1'b0, 1'b0, 16'h0020, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x || b !== 3 || w !== 1'b1) begin
            n_fail++; $display("FAIL rst_write_dropped data=%h busy=%0d memWr=%b exp %h/3/1", r, b, w, x);
        end
    endtask

    task automatic test_back_to_back();
        int b; logic w, e, aft; logic [15:0] r, x;
        logic [4:0] busy_pat, wr_pat;
        busy_pat = '0; wr_pat = '0;
        access(1, 1'b1, 1'b0, 16'h0000, 16'hCAFE, b, w, e, r, aft);
        n_checks++; if (b !== 1) begin n_fail++; $display("FAIL w0_wr_busy got=%0d exp=1", b); end
        access(1, 1'b1, 1'b0, 16'h0002, 16'hF00D, b, w, e, r, aft);
        @(negedge clk);
        sel_dut = 1'b1;
        rw = 1'b0; bop = 1'b0; adr = 16'h0000;
        en0 = 1'b1;
        exp_q.push_back(16'hCAFE);
        exp_q.push_back(16'hF00D);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) adr = 16'h0002;
            if (c == 2) en0 = 1'b0;
            @(negedge clk);
            busy_pat[c] = obs_busy;
            wr_pat[c]   = obs_wr;
            if (obs_wr) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra_read data=%h exp none", obs_data);
                end else begin
                    x = exp_q.pop_front();
                    n_checks++; if (obs_data !== x) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", obs_data, x); end
                end
            end
        end
        n_checks++; if (busy_pat !== 5'b00101) begin n_fail++; $display("FAIL b2b_busy_pattern got=%b exp=00101", busy_pat); end
        n_checks++; if (wr_pat !== 5'b01010) begin n_fail++; $display("FAIL b2b_memwr_pattern got=%b exp=01010", wr_pat); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_reads left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        exp_q.push_back(16'hCAFE);
        access(1, 1'b0, 1'b0, 16'h0400, 16'h0000, b, w, e, r, aft);
        x = exp_q.pop_front();
        n_checks++; if (r !== x || b !== 1 || w !== 1'b1) begin
            n_fail++; $display("FAIL alias_0400 data=%h busy=%0d memWr=%b exp %h/1/1", r, b, w, x);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_ops();
        test_misaligned();
        test_held_request();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
